// File: rtl/npc_bus_pkg.sv
// Shared bus definitions for the NPC core: arbiter FSM states and master IDs.
package npc_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } arb_state_t;

    typedef enum logic {
        IFU = 1'b0,
        LSU = 1'b1
    } master_t;

    localparam int NUM_MASTERS = 2;

    // The master that did not win last time; used to break ties fairly.
    function automatic master_t other_master(input master_t m);
        return (m == IFU) ? LSU : IFU;
    endfunction

endpackage

// File: rtl/Reg.sv
// Generic register with synchronous active-high reset and load enable.
module Reg #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    // Reset wins; otherwise load when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= RESET_VAL;
        end else if (en) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master single-port memory arbiter: serialises IFU reads and LSU
// reads/writes onto one memory port, one transaction outstanding at a time,
// with round-robin tie-breaking between the masters.
module mem_arbiter
    import npc_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    input  logic                ifu_resp_ready,
    output logic [DATA_W-1:0]   ifu_rdata,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    input  logic                lsu_resp_ready,
    output logic [DATA_W-1:0]   lsu_rdata,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int MASK_W = DATA_W / 8;

    arb_state_t state_reg;
    arb_state_t state_next;
    master_t    owner_reg;
    master_t    last_grant_reg;
    master_t    grant;
    logic       grant_valid;
    logic       accept;

    logic [1:0] state_bits;
    logic       owner_bit;
    logic       last_grant_bit;

    logic [ADDR_W-1:0] addr_reg;
    logic              wen_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [MASK_W-1:0] wmask_reg;
    logic [DATA_W-1:0] rdata_reg;

    logic [NUM_MASTERS-1:0] req_valid_vec;
    logic [NUM_MASTERS-1:0] req_ready_vec;
    logic [NUM_MASTERS-1:0] resp_valid_vec;
    logic [NUM_MASTERS-1:0] resp_ready_vec;

    assign req_valid_vec  = {lsu_req_valid, ifu_req_valid};
    assign resp_ready_vec = {lsu_resp_ready, ifu_resp_ready};

    // State, owner and last-grant registers.
    Reg #(.WIDTH(2), .RESET_VAL(2'(IDLE))) u_state_reg (
        .clk  (clk),
        .rst  (rst),
        .en   (1'b1),
        .din  (2'(state_next)),
        .dout (state_bits)
    );

    Reg #(.WIDTH(1), .RESET_VAL(1'(IFU))) u_owner_reg (
        .clk  (clk),
        .rst  (rst),
        .en   (accept),
        .din  (1'(grant)),
        .dout (owner_bit)
    );

    Reg #(.WIDTH(1), .RESET_VAL(1'(IFU))) u_last_grant_reg (
        .clk  (clk),
        .rst  (rst),
        .en   (accept),
        .din  (1'(grant)),
        .dout (last_grant_bit)
    );

    assign state_reg      = arb_state_t'(state_bits);
    assign owner_reg      = master_t'(owner_bit);
    assign last_grant_reg = master_t'(last_grant_bit);

    // Grant selection: single requester wins outright, ties go to the
    // master not granted last time. Only meaningful in IDLE outside reset.
    always_comb begin
        grant       = IFU;
        grant_valid = ifu_req_valid | lsu_req_valid;
        if (ifu_req_valid && lsu_req_valid) begin
            grant = other_master(last_grant_reg);
        end else if (lsu_req_valid) begin
            grant = LSU;
        end
        accept = (state_reg == IDLE) && grant_valid && !rst;
    end

    // Per-master ready/response-valid decode.
    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
            assign req_ready_vec[gi]  = accept && (grant == master_t'(1'(gi)))
                                        && req_valid_vec[gi];
            assign resp_valid_vec[gi] = (state_reg == RESP)
                                        && (owner_reg == master_t'(1'(gi)));
        end
    endgenerate

    assign ifu_req_ready  = req_ready_vec[IFU];
    assign lsu_req_ready  = req_ready_vec[LSU];
    assign ifu_resp_valid = resp_valid_vec[IFU];
    assign lsu_resp_valid = resp_valid_vec[LSU];
    assign ifu_rdata      = rdata_reg;
    assign lsu_rdata      = rdata_reg;

    assign mem_req_valid  = (state_reg == REQ);
    assign mem_addr       = addr_reg;
    assign mem_wen        = wen_reg;
    assign mem_wdata      = wdata_reg;
    assign mem_wmask      = wmask_reg;

    // Next-state logic: one request/response cycle per transaction.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept)                    state_next = REQ;
            REQ:  if (mem_req_ready)             state_next = WAIT;
            WAIT: if (mem_resp_valid)            state_next = RESP;
            RESP: if (resp_ready_vec[owner_reg]) state_next = IDLE;
            default:                             state_next = IDLE;
        endcase
    end

    // Request latch on accept and response capture in WAIT only.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_reg  <= '0;
            wen_reg   <= 1'b0;
            wdata_reg <= '0;
            wmask_reg <= '0;
            rdata_reg <= '0;
        end else begin
            if (accept) begin
                if (grant == LSU) begin
                    addr_reg  <= lsu_addr;
                    wen_reg   <= lsu_wen;
                    wdata_reg <= lsu_wdata;
                    wmask_reg <= lsu_wmask;
                end else begin
                    // Instruction fetches are always plain reads.
                    addr_reg  <= ifu_addr;
                    wen_reg   <= 1'b0;
                    wdata_reg <= '0;
                    wmask_reg <= '0;
                end
            end
            if ((state_reg == WAIT) && mem_resp_valid) begin
                rdata_reg <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: single reads, round-robin ties, LSU
// writes, back-pressure on both sides and reset mid-transaction.
module tb_mem_arbiter;
    import npc_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ifu_req_valid = 1'b0, ifu_req_ready, ifu_resp_valid;
    logic        ifu_resp_ready = 1'b1;
    logic [31:0] ifu_addr = '0, ifu_rdata;
    logic        lsu_req_valid = 1'b0, lsu_req_ready, lsu_resp_valid;
    logic        lsu_resp_ready = 1'b1;
    logic [31:0] lsu_addr = '0, lsu_wdata = '0, lsu_rdata;
    logic        lsu_wen = 1'b0;
    logic [3:0]  lsu_wmask = '0;
    logic        mem_req_valid, mem_wen;
    logic        mem_req_ready = 1'b1;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_rdata = '0;

    int tests = 0;
    int fails = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Apply reset for one edge; ready outputs must stay low even with requests up.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        step();
        chk({tag, ".ifu_rdy"}, 64'(ifu_req_ready), 64'd0);
        chk({tag, ".lsu_rdy"}, 64'(lsu_req_ready), 64'd0);
        chk({tag, ".mreq_v"},  64'(mem_req_valid), 64'd0);
        chk({tag, ".resp_v"},  64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
        chk({tag, ".addr"},    64'(mem_addr), 64'd0);
        rst = 1'b0;
    endtask

    // One full best-case transaction starting in IDLE with requests already driven.
    task automatic do_txn(input master_t who, input logic [31:0] addr, input logic w,
                          input logic [3:0] mask, input logic [31:0] wd,
                          input logic [31:0] rd, input string tag);
        #1;
        chk({tag, ".ifu_rdy"}, 64'(ifu_req_ready), 64'(who == IFU));
        chk({tag, ".lsu_rdy"}, 64'(lsu_req_ready), 64'(who == LSU));
        step();
        if (who == IFU) ifu_req_valid = 1'b0;
        else            lsu_req_valid = 1'b0;
        #1;
        chk({tag, ".mreq_v"},  64'(mem_req_valid), 64'd1);
        chk({tag, ".maddr"},   64'(mem_addr), 64'(addr));
        chk({tag, ".mwen"},    64'(mem_wen), 64'(w));
        chk({tag, ".mmask"},   64'(mem_wmask), 64'(mask));
        if (w) chk({tag, ".mwdata"}, 64'(mem_wdata), 64'(wd));
        chk({tag, ".rdy_req"}, 64'({ifu_req_ready, lsu_req_ready}), 64'd0);
        step();
        chk({tag, ".mreq_v_wait"}, 64'(mem_req_valid), 64'd0);
        mem_resp_valid = 1'b1;
        mem_rdata = rd;
        step();
        mem_resp_valid = 1'b0;
        mem_rdata = '0;
        #1;
        chk({tag, ".ifu_rv"}, 64'(ifu_resp_valid), 64'(who == IFU));
        chk({tag, ".lsu_rv"}, 64'(lsu_resp_valid), 64'(who == LSU));
        chk({tag, ".rdata"},  64'((who == IFU) ? ifu_rdata : lsu_rdata), 64'(rd));
        step();
        chk({tag, ".rv_done"}, 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
    endtask

    initial begin
        // Test 1: lone IFU read.
        do_reset("rst0");
        ifu_req_valid = 1'b1;
        ifu_addr = 32'h8000_0000;
        do_txn(IFU, 32'h8000_0000, 1'b0, 4'h0, 32'h0, 32'h0000_0413, "t1");

        // Test 2: ties from reset alternate LSU, IFU, LSU, IFU.
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        ifu_addr = 32'h8000_0004;
        lsu_addr = 32'h8000_0040;
        do_reset("rst2");
        do_txn(LSU, 32'h8000_0040, 1'b0, 4'h0, 32'h0, 32'h1111_0001, "t2a");
        lsu_req_valid = 1'b1;
        do_txn(IFU, 32'h8000_0004, 1'b0, 4'h0, 32'h0, 32'h2222_0002, "t2b");
        ifu_req_valid = 1'b1;
        do_txn(LSU, 32'h8000_0040, 1'b0, 4'h0, 32'h0, 32'h3333_0003, "t2c");
        lsu_req_valid = 1'b1;
        do_txn(IFU, 32'h8000_0004, 1'b0, 4'h0, 32'h0, 32'h4444_0004, "t2d");
        lsu_req_valid = 1'b0;

        // Test 3: LSU write, then an IFU read must not inherit write qualifiers.
        lsu_req_valid = 1'b1;
        lsu_wen = 1'b1;
        lsu_addr = 32'h8000_0100;
        lsu_wdata = 32'hDEAD_BEEF;
        lsu_wmask = 4'b0011;
        do_txn(LSU, 32'h8000_0100, 1'b1, 4'b0011, 32'hDEAD_BEEF, 32'h5555_0005, "t3w");
        ifu_req_valid = 1'b1;
        ifu_addr = 32'h8000_0008;
        do_txn(IFU, 32'h8000_0008, 1'b0, 4'h0, 32'h0, 32'h6666_0006, "t3r");
        lsu_wen = 1'b0;
        lsu_wmask = 4'h0;

        // Test 4: memory stall then IFU response stall; LSU waits throughout.
        ifu_req_valid = 1'b1;
        ifu_addr = 32'h8000_0200;
        mem_req_ready = 1'b0;
        #1;
        chk("t4.ifu_rdy", 64'(ifu_req_ready), 64'd1);
        step();
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b1;
        lsu_addr = 32'h8000_0300;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("t4.stall%0d.mreq_v", i), 64'(mem_req_valid), 64'd1);
            chk($sformatf("t4.stall%0d.maddr", i), 64'(mem_addr), 64'h8000_0200);
            chk($sformatf("t4.stall%0d.lsu_rdy", i), 64'(lsu_req_ready), 64'd0);
            mem_resp_valid = (i == 2);
            mem_rdata = 32'hBAD0_BAD0;
            step();
        end
        mem_resp_valid = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        chk("t4.mreq_v_last", 64'(mem_req_valid), 64'd1);
        step();
        mem_resp_valid = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        ifu_resp_ready = 1'b0;
        step();
        mem_resp_valid = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("t4.hold%0d.ifu_rv", i), 64'(ifu_resp_valid), 64'd1);
            chk($sformatf("t4.hold%0d.rdata", i), 64'(ifu_rdata), 64'hCAFE_F00D);
            chk($sformatf("t4.hold%0d.lsu_rdy", i), 64'(lsu_req_ready), 64'd0);
            step();
        end
        ifu_resp_ready = 1'b1;
        #1;
        chk("t4.ifu_rv_final", 64'(ifu_resp_valid), 64'd1);
        chk("t4.lsu_rdy_final", 64'(lsu_req_ready), 64'd0);
        step();
        do_txn(LSU, 32'h8000_0300, 1'b0, 4'h0, 32'h0, 32'h7777_0007, "t4l");

        // Test 5: reset during WAIT, stray response, then LSU wins the tie.
        lsu_req_valid = 1'b1;
        lsu_addr = 32'h8000_0400;
        #1;
        chk("t5.lsu_rdy", 64'(lsu_req_ready), 64'd1);
        step();
        lsu_req_valid = 1'b0;
        step();
        chk("t5.in_wait", 64'(mem_req_valid), 64'd0);
        do_reset("t5.rst");
        step();
        mem_resp_valid = 1'b1;
        mem_rdata = 32'hDEAD_0000;
        step();
        mem_resp_valid = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("t5.stray%0d.rv", i), 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
            chk($sformatf("t5.stray%0d.mreq_v", i), 64'(mem_req_valid), 64'd0);
            step();
        end
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        ifu_addr = 32'h8000_0010;
        do_txn(LSU, 32'h8000_0400, 1'b0, 4'h0, 32'h0, 32'h8888_0008, "t5l");
        do_txn(IFU, 32'h8000_0010, 1'b0, 4'h0, 32'h0, 32'h9999_0009, "t5i");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
